rl_burst_scheduler: RTL

- Single-clock scheduler that arbitrates between a readout requester and a gain-load requester for the shared gain register path.
- Generates mutually exclusive READ_G / LOAD_G pulse bursts.
- Drives the R_L_con mode level consumed by the read/load mutual-exclusion logic.
- Inserts guard time on every read/load mode change so the mode level is always settled before the first pulse of a burst.

---
 rtl/rl_sched_pkg.sv | 14 +
 rtl/rl_pulse_gen.sv | 73 +++++++
 rtl/rl_burst_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rl_sched_pkg.sv
// Shared types for the read/load burst scheduler: FSM states, mode encoding
// and the counter width helper used to size the pulse and guard counters.
package rl_sched_pkg;

  typedef enum logic [1:0] {IDLE, GUARD, BURST, DONE} state_t;

  localparam logic MODE_READ = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/rl_pulse_gen.sv
// Loadable pulse train: on start emits count pulses of hi_len high / lo_len low, pulse registered
// (high the cycle after start); last flags the final low cycle; abort ends the current high phase early.
module rl_pulse_gen #(
  parameter int CW = 4,
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic [PW-1:0] hi_len,
  input  logic [PW-1:0] lo_len,
  input  logic          abort,
  output logic          pulse,
  output logic          last
);

  logic          active_q;
  logic          hi_q;
  logic          aborted_q;
  logic [PW-1:0] phase_q;
  logic [CW-1:0] idx_q;
  logic [CW-1:0] count_q;
  logic          lo_end;

  assign lo_end = active_q & ~hi_q & (phase_q == lo_len);
  // An abort seen during the low phase still lets that low phase finish.
  assign last   = lo_end & ((idx_q == count_q) | aborted_q | abort);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      hi_q      <= 1'b0;
      aborted_q <= 1'b0;
      pulse     <= 1'b0;
      phase_q   <= '0;
      idx_q     <= '0;
      count_q   <= '0;
    end else if (start) begin
      active_q  <= 1'b1;
      hi_q      <= 1'b1;
      aborted_q <= 1'b0;
      pulse     <= 1'b1;
      phase_q   <= PW'(1);
      idx_q     <= CW'(1);
      count_q   <= count;
    end else if (active_q) begin
      if (hi_q) begin
        if (abort || (phase_q == hi_len)) begin
          hi_q    <= 1'b0;
          pulse   <= 1'b0;
          phase_q <= PW'(1);
        end else begin
          phase_q <= phase_q + 1'b1;
        end
        if (abort) aborted_q <= 1'b1;
      end else if (lo_end) begin
        if (last) begin
          active_q <= 1'b0;
        end else begin
          hi_q    <= 1'b1;
          pulse   <= 1'b1;
          phase_q <= PW'(1);
          idx_q   <= idx_q + 1'b1;
        end
      end else begin
        phase_q <= phase_q + 1'b1;
        if (abort) aborted_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rl_burst_scheduler.sv
// Read/load burst scheduler: 1-cycle (same mode) or GUARD_CYC+1 (mode change) request-to-strobe latency;
// requests sampled only in IDLE and held until done. Optional RL_ABORT_EN adds ld_abort.
module rl_burst_scheduler
  import rl_sched_pkg::*;
#(
  parameter int READ_WORDS  = 8,
  parameter int LOAD_PULSES = 7,
  parameter int PULSE_HI    = 2,
  parameter int PULSE_LO    = 2,
  parameter int GUARD_CYC   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_req,
  input  logic ld_req,
`ifdef RL_ABORT_EN
  input  logic ld_abort,
`endif
  output logic rd_gnt,
  output logic ld_gnt,
  output logic read_g,
  output logic load_g,
  output logic r_l_con,
  output logic rd_done,
  output logic ld_done,
  output logic busy
);

  localparam int CW = cnt_width(READ_WORDS, LOAD_PULSES);
  localparam int PW = cnt_width(PULSE_HI, PULSE_LO);
  localparam int GW = cnt_width(GUARD_CYC, GUARD_CYC);

  state_t        state_q, state_d;
  logic          r_l_con_d;
  logic          last_served_q, last_served_d;
  logic [GW-1:0] guard_q, guard_d;
  logic          rd_gnt_d, ld_gnt_d, rd_done_d, ld_done_d, busy_d;
  logic          win;
  logic          pg_start, pg_pulse, pg_last, abort;
  logic [CW-1:0] pg_count;

`ifdef RL_ABORT_EN
  assign abort = ld_abort;
`else
  assign abort = 1'b0;
`endif

  // Tie goes to the mode that was not served last.
  assign win      = (rd_req & ld_req) ? ~last_served_q : ld_req;
  assign pg_count = (r_l_con_d == MODE_LOAD) ? CW'(LOAD_PULSES) : CW'(READ_WORDS);

  // r_l_con only ever moves on the IDLE->GUARD edge, so the strobe steering is glitch-free.
  assign read_g = pg_pulse & (r_l_con == MODE_READ);
  assign load_g = pg_pulse & (r_l_con == MODE_LOAD);

  rl_pulse_gen #(.CW(CW), .PW(PW)) u_pulse_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (pg_start),
    .count  (pg_count),
    .hi_len (PW'(PULSE_HI)),
    .lo_len (PW'(PULSE_LO)),
    .abort  (abort),
    .pulse  (pg_pulse),
    .last   (pg_last)
  );

  always_comb begin
    state_d       = state_q;
    r_l_con_d     = r_l_con;
    last_served_d = last_served_q;
    guard_d       = guard_q;
    rd_done_d     = 1'b0;
    ld_done_d     = 1'b0;
    pg_start      = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req | ld_req) begin
          if (win == r_l_con) begin
            state_d  = BURST;
            pg_start = 1'b1;
          end else begin
            state_d   = GUARD;
            r_l_con_d = win;
            guard_d   = GW'(1);
          end
        end
      end
      GUARD: begin
        if (guard_q == GW'(GUARD_CYC)) begin
          state_d  = BURST;
          pg_start = 1'b1;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      BURST: begin
        if (pg_last) begin
          state_d       = DONE;
          last_served_d = r_l_con;
          rd_done_d     = (r_l_con == MODE_READ);
          ld_done_d     = (r_l_con == MODE_LOAD);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rd_gnt_d = (state_d == BURST) & (r_l_con_d == MODE_READ);
    ld_gnt_d = (state_d == BURST) & (r_l_con_d == MODE_LOAD);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      r_l_con       <= MODE_READ;
      last_served_q <= MODE_LOAD;
      guard_q       <= '0;
      rd_gnt        <= 1'b0;
      ld_gnt        <= 1'b0;
      rd_done       <= 1'b0;
      ld_done       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      r_l_con       <= r_l_con_d;
      last_served_q <= last_served_d;
      guard_q       <= guard_d;
      rd_gnt        <= rd_gnt_d;
      ld_gnt        <= ld_gnt_d;
      rd_done       <= rd_done_d;
      ld_done       <= ld_done_d;
      busy          <= busy_d;
    end
  end

endmodule
